// File: rtl/bf_loader_if.sv
// Bus between the program loader and its surroundings: control inputs,
// ROM address/data pair, and the front-panel strobe/switch outputs.
interface bf_loader_if #(
    parameter int AW = 6
);
    logic          start;
    logic [AW-1:0] len;
    logic          stop;
    logic [AW-1:0] prog_addr;
    logic [2:0]    prog_data;
    logic          push;
    logic [7:0]    sw;
    logic          busy;
    logic          done;

    modport master (
        output start, len, stop, prog_data,
        input  prog_addr, push, sw, busy, done
    );

    modport slave (
        input  start, len, stop, prog_data,
        output prog_addr, push, sw, busy, done
    );
endinterface

// File: rtl/bf_loader.sv
// Feeds opcodes from a program ROM into the des3 front panel as push strobes,
// then raises the run switch until told to stop. Every output is a register.
module bf_loader #(
    parameter int SETUP  = 1,
    parameter int PUSH_W = 1,
    parameter int AW     = 6
) (
    input  logic       clk,
    input  logic       rst,
    bf_loader_if.slave bus
);

    localparam int CMAX = (SETUP > PUSH_W) ? SETUP : PUSH_W;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP - 1);
    localparam logic [CW-1:0] PUSH_LAST  = CW'(PUSH_W - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SETUP_ST = 3'd2,
        PHI   = 3'd3,
        PLO   = 3'd4,
        RUN   = 3'd5
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [AW-1:0] idx, idx_n;
    logic [AW-1:0] n, n_n;
    logic [AW-1:0] addr, addr_n;
    logic [2:0]    op, op_n;
    logic          run, run_n;
    logic          push, push_n;
    logic          done, done_n;
    logic          busy, busy_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            n     <= '0;
            addr  <= '0;
            op    <= '0;
            run   <= 1'b0;
            push  <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            n     <= n_n;
            addr  <= addr_n;
            op    <= op_n;
            run   <= run_n;
            push  <= push_n;
            done  <= done_n;
            busy  <= busy_n;
        end
    end

    // Next values are computed for the registers themselves, so each output
    // changes exactly on the edge that enters the corresponding state.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        n_n     = n;
        addr_n  = addr;
        op_n    = op;
        run_n   = run;
        push_n  = 1'b0;
        done_n  = 1'b0;
        busy_n  = 1'b1;

        unique case (state)
            IDLE: begin
                busy_n = 1'b0;
                if (bus.start) begin
                    busy_n = 1'b1;
                    if (bus.len != '0) begin
                        state_n = FETCH;
                        idx_n   = '0;
                        addr_n  = '0;
                        n_n     = bus.len;
                    end else begin
                        state_n = RUN;
                        run_n   = 1'b1;
                        done_n  = 1'b1;
                    end
                end
            end
            FETCH: begin
                op_n    = bus.prog_data;
                cnt_n   = SETUP_LAST;
                state_n = SETUP_ST;
            end
            SETUP_ST: begin
                if (cnt == '0) begin
                    state_n = PHI;
                    push_n  = 1'b1;
                    cnt_n   = PUSH_LAST;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            PHI: begin
                push_n = 1'b1;
                if (cnt == '0) begin
                    push_n  = 1'b0;
                    state_n = PLO;
                    cnt_n   = PUSH_LAST;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            PLO: begin
                if (cnt == '0) begin
                    if (idx == n - AW'(1)) begin
                        state_n = RUN;
                        run_n   = 1'b1;
                        done_n  = 1'b1;
                    end else begin
                        idx_n   = idx + AW'(1);
                        addr_n  = idx + AW'(1);
                        state_n = FETCH;
                    end
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_n = IDLE;
                    run_n   = 1'b0;
                    busy_n  = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    assign bus.prog_addr = addr;
    assign bus.push      = push;
    assign bus.sw        = {run, 4'b0000, op};
    assign bus.busy      = busy;
    assign bus.done      = done;

endmodule

// File: tb/tb_bf_loader.sv
// Directed bench for bf_loader: default timing on one instance, stretched
// SETUP/PUSH_W timing on a second, with hand-computed cycle expectations.
module tb_bf_loader;

    localparam int AW = 6;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [2:0] rom0 [64];
    logic [2:0] rom1 [64];

    logic [2:0] progA [18] = '{3'o2, 3'o2, 3'o2, 3'o6, 3'o0, 3'o2, 3'o0, 3'o2, 3'o2,
                               3'o1, 3'o1, 3'o3, 3'o7, 3'o4, 3'o0, 3'o4, 3'o0, 3'o4};
    logic [2:0] progB [18] = '{3'o2, 3'o2, 3'o6, 3'o0, 3'o2, 3'o2, 3'o0, 3'o2, 3'o1,
                               3'o1, 3'o3, 3'o7, 3'o2, 3'o4, 3'o0, 3'o4, 3'o0, 3'o4};

    bf_loader_if #(.AW(AW)) bus0 ();
    bf_loader_if #(.AW(AW)) bus1 ();

    assign bus0.prog_data = rom0[bus0.prog_addr];
    assign bus1.prog_data = rom1[bus1.prog_addr];

    bf_loader #(.SETUP(1), .PUSH_W(1), .AW(AW)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    bf_loader #(.SETUP(2), .PUSH_W(3), .AW(AW)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts a load on dut0 and follows it cycle by cycle: each push rise must
    // land at 2+4k with ROM word k on sw[2:0]; RUN and done arrive at cycle 4n.
    task automatic runLoad(input string tag, input int nops, input bit disturb);
        int rises;
        int doneCount;
        bit prevPush;
        rises     = 0;
        doneCount = 0;
        prevPush  = 1'b0;
        checkOutput({tag, "_idle_sw7"}, 32'(bus0.sw[7]), 32'd0);
        bus0.start = 1'b1;
        bus0.len   = AW'(nops);
        step();
        bus0.start = 1'b0;
        checkOutput({tag, "_busy"}, 32'(bus0.busy), 32'd1);
        checkOutput({tag, "_addr0"}, 32'(bus0.prog_addr), 32'd0);
        for (int cyc = 1; cyc <= nops * 4 + 2; cyc++) begin
            if (disturb && cyc == 9) begin
                bus0.start = 1'b1;
                bus0.len   = AW'(3);
            end
            if (disturb && cyc == 10) bus0.start = 1'b0;
            step();
            if (bus0.done) doneCount++;
            if (bus0.push && !prevPush) begin
                if (rises < nops) begin
                    checkOutput({tag, "_op"}, 32'(bus0.sw[2:0]), 32'(rom0[rises]));
                    checkOutput({tag, "_rise_cyc"}, 32'(cyc), 32'(2 + 4 * rises));
                end
                rises++;
            end
            prevPush = bus0.push;
            if (cyc == nops * 4 - 1) checkOutput({tag, "_sw7_early"}, 32'(bus0.sw[7]), 32'd0);
            if (cyc == nops * 4) begin
                checkOutput({tag, "_done"}, 32'(bus0.done), 32'd1);
                checkOutput({tag, "_sw7"}, 32'(bus0.sw[7]), 32'd1);
            end
        end
        checkOutput({tag, "_rises"}, 32'(rises), 32'(nops));
        checkOutput({tag, "_done_count"}, 32'(doneCount), 32'd1);
        checkOutput({tag, "_busy_run"}, 32'(bus0.busy), 32'd1);
    endtask

    task automatic stopRun(input string tag);
        bus0.stop = 1'b1;
        step();
        bus0.stop = 1'b0;
        checkOutput({tag, "_stop_sw7"}, 32'(bus0.sw[7]), 32'd0);
        checkOutput({tag, "_stop_busy"}, 32'(bus0.busy), 32'd0);
    endtask

    initial begin
        int pushes;
        int doneCount;
        checks = 0;
        errors = 0;
        bus0.start = 1'b0;
        bus0.len   = '0;
        bus0.stop  = 1'b0;
        bus1.start = 1'b0;
        bus1.len   = '0;
        bus1.stop  = 1'b0;
        for (int i = 0; i < 64; i++) begin
            rom0[i] = 3'o0;
            rom1[i] = 3'o0;
        end
        for (int i = 0; i < 18; i++) rom0[i] = progA[i];
        rom1[0] = 3'o5;
        rom1[1] = 3'o3;

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checkOutput("rst_push", 32'(bus0.push), 32'd0);
        checkOutput("rst_sw", 32'(bus0.sw), 32'd0);
        checkOutput("rst_busy", 32'(bus0.busy), 32'd0);
        checkOutput("rst_done", 32'(bus0.done), 32'd0);
        step();

        // Program A, then stop and load program B.
        runLoad("loadA", 18, 1'b0);
        step();
        stopRun("loadA");
        for (int i = 0; i < 18; i++) rom0[i] = progB[i];
        step();
        runLoad("loadB", 18, 1'b0);
        stopRun("loadB");

        // Zero-length load goes straight to RUN with no strobes.
        step();
        bus0.start = 1'b1;
        bus0.len   = '0;
        bus0.stop  = 1'b1;
        step();
        bus0.start = 1'b0;
        bus0.stop  = 1'b0;
        checkOutput("len0_done", 32'(bus0.done), 32'd1);
        checkOutput("len0_sw7", 32'(bus0.sw[7]), 32'd1);
        checkOutput("len0_busy", 32'(bus0.busy), 32'd1);
        pushes = (bus0.push === 1'b1) ? 1 : 0;
        doneCount = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus0.push === 1'b1) pushes++;
            if (bus0.done === 1'b1) doneCount++;
        end
        checkOutput("len0_pushes", 32'(pushes), 32'd0);
        checkOutput("len0_done_once", 32'(doneCount), 32'd0);
        stopRun("len0");

        // Re-pulsed start with a new len during the load is ignored.
        step();
        runLoad("repulse", 18, 1'b1);
        stopRun("repulse");
        bus0.len = '0;

        // Reset asserted while push is high.
        step();
        bus0.start = 1'b1;
        bus0.len   = AW'(18);
        step();
        bus0.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus0.push === 1'b1) break;
            step();
        end
        checkOutput("rstmid_in_phi", 32'(bus0.push), 32'd1);
        rst = 1'b1;
        step();
        checkOutput("rstmid_push", 32'(bus0.push), 32'd0);
        checkOutput("rstmid_sw", 32'(bus0.sw), 32'd0);
        checkOutput("rstmid_busy", 32'(bus0.busy), 32'd0);
        checkOutput("rstmid_addr", 32'(bus0.prog_addr), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();
        checkOutput("rstmid_idle", 32'(bus0.busy), 32'd0);
        checkOutput("rstmid_push_after", 32'(bus0.push), 32'd0);

        // Stretched timing: P = 1+2+2*3 = 9, push high cycles 3..5 and 12..14.
        bus1.start = 1'b1;
        bus1.len   = AW'(2);
        step();
        bus1.start = 1'b0;
        checkOutput("slow_busy", 32'(bus1.busy), 32'd1);
        for (int cyc = 1; cyc <= 19; cyc++) begin
            step();
            checkOutput($sformatf("slow_push_c%0d", cyc), 32'(bus1.push),
                        32'(((cyc >= 3 && cyc <= 5) || (cyc >= 12 && cyc <= 14)) ? 1 : 0));
            checkOutput($sformatf("slow_op_c%0d", cyc), 32'(bus1.sw[2:0]),
                        32'((cyc >= 10) ? 3'o3 : 3'o5));
            checkOutput($sformatf("slow_sw7_c%0d", cyc), 32'(bus1.sw[7]),
                        32'((cyc >= 18) ? 1 : 0));
            checkOutput($sformatf("slow_done_c%0d", cyc), 32'(bus1.done),
                        32'((cyc == 18) ? 1 : 0));
            if (cyc == 9) checkOutput("slow_addr1", 32'(bus1.prog_addr), 32'd1);
        end
        bus1.stop = 1'b1;
        step();
        bus1.stop = 1'b0;
        checkOutput("slow_stop_busy", 32'(bus1.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bf_loader.md
# bf_loader

Hardware program loader for the Brainfuck core (`des3`), driving the core's front-panel entry interface (`push`, `sw`) in place of a human or bench. On a `start` pulse it reads `len` 3-bit opcodes from a program ROM. It presents each opcode on `sw[2:0]` with a debounced-style `push` pulse, then raises the run switch `sw[7]` and holds it until `stop`. It sits between a program ROM and `des3`; the core's outputs are not used.

## Interface
Parameters:
- `SETUP`, 1: cycles `sw[2:0]` is stable before `push` rises (≥1)
- `PUSH_W`, 1: cycles `push` is high, and then low, per opcode (≥1)
- `AW`, 6: program address width (max 2^AW opcodes)

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: begin load; sampled only in IDLE
- `len` in AW: opcode count, sampled on accepted `start`
- `stop` in 1: leave RUN; ignored in other states
- `prog_addr` out AW: registered ROM address
- `prog_data` in 3: opcode; combinational function of `prog_addr`, valid in the same cycle
- `push` out 1: entry strobe to core
- `sw` out 8: `[2:0]` opcode, `[6:3]` always 0, `[7]` run switch
- `busy` out 1: high in any state except IDLE
- `done` out 1: one-cycle pulse on the first RUN cycle

## Operation
- States: IDLE, FETCH, SETUP, PHI, PLO, RUN. Internal: `idx` (AW bits), `cnt`, and latched `n`, which is `len`.
- IDLE:
  - `start`=1 and `len`≠0 → FETCH, with `idx`←0, `prog_addr`←0, `n`←`len`.
  - `start`=1 and `len`=0 → RUN directly. `done` still pulses.
- FETCH (1 cycle): `sw[2:0]`←`prog_data` at exit edge → SETUP.
- SETUP (SETUP cycles): `push`=0, `sw[2:0]` held → PHI.
- PHI (PUSH_W cycles): `push`=1, `sw[2:0]` held → PLO.
- PLO (PUSH_W cycles): `push`=0. On exit:
  - If `idx`=`n`−1 → RUN.
  - Else `idx`++, `prog_addr`←`idx`+1 → FETCH.
- RUN: `sw[7]`=1, `sw[2:0]` keeps the last opcode. `stop`=1 → IDLE, with `sw[7]`←0 on that edge.
- `start` outside IDLE is ignored. `len` changes after acceptance have no effect.
- `n`=2^AW−1 is the maximum count; `idx` never wraps. `prog_addr` never exceeds `n`−1.
- `start` and `stop` asserted together in IDLE: `start` wins, `stop` is ignored.

## Timing
- Reset values: `push`=0, `sw`=8'h00, `prog_addr`=0, `busy`=0, `done`=0, state IDLE.
- `rst` mid-load or mid-RUN returns everything to reset values on the next edge. No partial push is completed.
- All outputs are registered; no combinational path from inputs to outputs.
- `start` accepted at edge E0. Then:
  - `busy`=1 from E0.
  - `prog_addr`=0 from E0.
  - `sw[2:0]`=op0 from E0+1.
  - `push` rises at E0+1+SETUP.
- Cycles per opcode: P = 1+SETUP+2·PUSH_W (4 at defaults).
- `sw[7]` and `done` rise at E0+n·P. `done` falls one edge later.
- `push` is never high while `sw[2:0]` changes. `sw[2:0]` changes only at the FETCH exit edge.
- `stop` asserted in the cycle before edge Es: `sw[7]`=0 and `busy`=0 from Es.

## Test plan
- Reset: hold `rst` 3 cycles mid-PHI.
  - Required: `push`=0, `sw`=0, `busy`=0, `prog_addr`=0 the cycle after the first `rst` edge.
- Full load, defaults, ROM = octal 2,2,2,6,0,2,0,2,2,1,1,3,7,4,0,4,0,4, `len`=18, one-cycle `start`:
  - Exactly 18 `push` rising edges, 4 cycles apart.
  - `sw[2:0]` at each rising edge matches the ROM in order.
  - `sw[7]`=1 and `done` pulse at start+72 cycles.
- Second program 2,2,6,0,2,2,0,2,1,1,3,7,2,4,0,4,0,4:
  - `stop`, then `start` again.
  - Same checks as the full-load scenario; `sw[7]` is 0 between the two loads.
- `len`=0: `start` → `done` pulse and `sw[7]`=1 on the next edge, with no `push` pulses.
- `start` re-pulsed during load and `len` changed to 3 mid-load:
  - Load still completes 18 opcodes.
  - `done` pulses once.
- SETUP=2, PUSH_W=3, `len`=2:
  - `push` high 3 cycles, opcode stable ≥2 cycles before each rise.
  - RUN reached at start+18 cycles.
